// File: rtl/cnn_core_div_22s_6s_16_seq.sv
// Radix-2 restoring signed divider: 22s / 6s -> 16s saturated quotient plus remainder.
// Define CNN_CORE_DIV_REM_EN to build the remainder output; otherwise rem is tied to 0.
module cnn_core_div_22s_6s_16_seq #(
    parameter int DIN0_WIDTH = 22,
    parameter int DIN1_WIDTH = 6,
    parameter int QUOT_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_WIDTH-1:0] quot,
    output logic [DIN1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(DIN0_WIDTH);
    localparam logic [QUOT_WIDTH-1:0] QMAX = {1'b0, {(QUOT_WIDTH-1){1'b1}}};
    localparam logic [QUOT_WIDTH-1:0] QMIN = {1'b1, {(QUOT_WIDTH-1){1'b0}}};
    localparam logic [DIN0_WIDTH-1:0] QPOS_LIM = DIN0_WIDTH'(QMAX);
    localparam logic [DIN0_WIDTH-1:0] QNEG_LIM = DIN0_WIDTH'(QMIN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIN0_WIDTH-1:0]   dvd_q, dvd_d;
    logic [DIN1_WIDTH-1:0]   dvs_q, dvs_d;
    logic [DIN1_WIDTH-1:0]   prem_q, prem_d;
    logic                    qneg_q, qneg_d;
    logic                    rneg_q, rneg_d;
    logic                    zero_q, zero_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [QUOT_WIDTH-1:0]   quot_q, quot_d;
    logic                    dbz_q, dbz_d;
    logic                    ovf_q, ovf_d;
    logic [DIN1_WIDTH:0]     shifted;
    logic [DIN1_WIDTH:0]     trial;
    logic                    take;
`ifdef CNN_CORE_DIV_REM_EN
    logic [DIN1_WIDTH-1:0]   rem_q, rem_d;
`endif

    // dvd_q shifts dividend magnitude out of its MSB while quotient bits enter at the LSB
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
`ifdef CNN_CORE_DIV_REM_EN
        rem_d       = rem_q;
`endif
        shifted = {prem_q, dvd_q[DIN0_WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        take    = shifted >= {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    dvd_d      = din0[DIN0_WIDTH-1] ? -din0 : din0;
                    dvs_d      = din1[DIN1_WIDTH-1] ? -din1 : din1;
                    prem_d     = '0;
                    qneg_d     = din0[DIN0_WIDTH-1] ^ din1[DIN1_WIDTH-1];
                    rneg_d     = din0[DIN0_WIDTH-1];
                    zero_d     = (din1 == '0);
                    cnt_d      = CNT_W'(DIN0_WIDTH - 1);
                end
            end
            CALC: begin
                prem_d = take ? trial[DIN1_WIDTH-1:0] : shifted[DIN1_WIDTH-1:0];
                dvd_d  = {dvd_q[DIN0_WIDTH-2:0], take};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                dbz_d = 1'b0;
                ovf_d = 1'b0;
                if (zero_q) begin
                    quot_d = rneg_q ? QMIN : QMAX;
                    dbz_d  = 1'b1;
                end else if (!qneg_q && dvd_q > QPOS_LIM) begin
                    quot_d = QMAX;
                    ovf_d  = 1'b1;
                end else if (qneg_q && dvd_q > QNEG_LIM) begin
                    quot_d = QMIN;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = qneg_q ? -dvd_q[QUOT_WIDTH-1:0] : dvd_q[QUOT_WIDTH-1:0];
                end
`ifdef CNN_CORE_DIV_REM_EN
                rem_d = zero_q ? '0 : (rneg_q ? -prem_q : prem_q);
`endif
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef CNN_CORE_DIV_REM_EN
            rem_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
`ifdef CNN_CORE_DIV_REM_EN
            rem_q       <= rem_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quot        = quot_q;
    assign div_by_zero = dbz_q;
    assign ovf         = ovf_q;
`ifdef CNN_CORE_DIV_REM_EN
    assign rem         = rem_q;
`else
    assign rem         = '0;
`endif

endmodule

// File: tb/tb_cnn_core_div_22s_6s_16_seq.sv
// Self-checking bench for cnn_core_div_22s_6s_16_seq: directed cases, random operands,
// backpressure and mid-operation reset, compared against plain C-style integer division.
module tb_cnn_core_div_22s_6s_16_seq;

    localparam int W0 = 22;
    localparam int W1 = 6;
    localparam int WQ = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W0-1:0] din0 = '0;
    logic [W1-1:0] din1 = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WQ-1:0] quot;
    logic [W1-1:0] rem;
    logic          div_by_zero;
    logic          ovf;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [WQ-1:0] exp_quot;
    logic [W1-1:0] exp_rem;
    logic          exp_dz;
    logic          exp_ov;
    logic [31:0]   rnd;
    logic [WQ-1:0] held_quot;

    cnn_core_div_22s_6s_16_seq #(
        .DIN0_WIDTH(W0),
        .DIN1_WIDTH(W1),
        .QUOT_WIDTH(WQ)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: C division truncates toward zero and the remainder takes the dividend's sign
    task automatic model(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b);
        longint q, r, qmax, qmin;
        qmax = (longint'(1) <<< (WQ - 1)) - 1;
        qmin = -(longint'(1) <<< (WQ - 1));
        exp_dz = 1'b0;
        exp_ov = 1'b0;
        if (b == 0) begin
            q = (a >= 0) ? qmax : qmin;
            r = 0;
            exp_dz = 1'b1;
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
            if (q > qmax) begin
                q = qmax;
                exp_ov = 1'b1;
            end else if (q < qmin) begin
                q = qmin;
                exp_ov = 1'b1;
            end
        end
        exp_quot = q[WQ-1:0];
`ifdef CNN_CORE_DIV_REM_EN
        exp_rem = r[W1-1:0];
`else
        exp_rem = '0;
`endif
    endtask

    task automatic send(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        model(a, b);
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        tick();
        in_valid = 1'b0;
        rnd = $urandom;
        din0 = rnd[W0-1:0];
        din1 = rnd[W0+W1-1:W0];
    endtask

    task automatic collect(input string tag);
        int n;
        n = 1;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd24);
        check({tag, "_quot"}, 32'(quot), 32'(exp_quot));
        check({tag, "_rem"}, 32'(rem), 32'(exp_rem));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dz));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ov));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            tick();
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_quot_hold"}, 32'(quot), 32'(exp_quot));
        end
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();

        // Directed sign, divide-by-zero and saturation cases
        send(22'sd1000, 6'sd7);          collect("pp");
        send(-22'sd1000, 6'sd7);         collect("np");
        send(22'sd1000, -6'sd7);         collect("pn");
        send(-22'sd1000, -6'sd7);        collect("nn");
        send(22'sd500, 6'sd0);           collect("dz_pos");
        send(-22'sd500, 6'sd0);          collect("dz_neg");
        send(22'sd2097151, 6'sd1);       collect("sat_pos");
        send(22'h200000, 6'sd1);         collect("sat_neg");
        send(22'h200000, -6'sd1);        collect("sat_negneg");
        send(-22'sd32768, 6'sd1);        collect("min_exact");
        send(22'sd2097151, 6'h20);       collect("div_m32");
        send(22'h200000, 6'sd31);        collect("min_by_31");

        // Random operands
        for (int i = 0; i < 16; i++) begin
            rnd = $urandom;
            send(rnd[W0-1:0], rnd[W0+W1-1:W0]);
            collect("rand");
        end

        // Backpressure: result held while a new request waits
        out_ready = 1'b0;
        send(22'sd1000, 6'sd7);
        collect("bp");
        held_quot = exp_quot;
        in_valid = 1'b1;
        din0 = 22'sd5;
        din1 = 6'sd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_quot", 32'(quot), 32'(held_quot));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        model(22'sd5, 6'sd1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", 32'(in_ready), 32'd0);
        collect("bp_next");
        out_ready = 1'b1;
        tick();
        check("bp_next_drop", 32'(out_valid), 32'd0);

        // Reset in the middle of CALC
        send(22'sd12345, 6'sd3);
        repeat (9) tick();
        ap_rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_quot", 32'(quot), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();
        send(22'sd100, 6'sd5);
        collect("after_rst");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
